// File: rtl/gaussian_window_filter_if.sv
// rtl/gaussian_window_filter_if.sv - row-stream input and filtered-pixel output bundle
interface gaussian_window_filter_if #(
  parameter int CH_W     = 8,
  parameter int CHANNELS = 3
);
  logic                     valid_in;
  logic [1:0]               mode;
  logic [CH_W*CHANNELS-1:0] din1;
  logic [CH_W*CHANNELS-1:0] din2;
  logic [CH_W*CHANNELS-1:0] din3;
  logic [CH_W*CHANNELS-1:0] din4;
  logic [CH_W*CHANNELS-1:0] din5;
  logic [CH_W*CHANNELS-1:0] dout;
  logic                     valid_out;
  logic                     eol_out;

  modport master (
    output valid_in, mode, din1, din2, din3, din4, din5,
    input  dout, valid_out, eol_out
  );

  modport slave (
    input  valid_in, mode, din1, din2, din3, din4, din5,
    output dout, valid_out, eol_out
  );
endinterface

// File: rtl/gaussian_window_filter.sv
// rtl/gaussian_window_filter.sv - 5-row tap window with bypass, 3x3 and 5x5 Gaussian output
module gaussian_window_filter #(
  parameter int CH_W      = 8,
  parameter int CHANNELS  = 3,
  parameter int PIC_WIDTH = 640
) (
  input logic                    clk,
  input logic                    rst,
  gaussian_window_filter_if.slave px
);
  localparam int PW    = CH_W * CHANNELS;
  localparam int SUM_W = CH_W + 9;
  localparam int COL_W = $clog2(PIC_WIDTH);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(PIC_WIDTH - 1);
  localparam logic [SUM_W:0]   MAX_PIX  = (SUM_W + 1)'((1 << CH_W) - 1);
  localparam logic [SUM_W:0]   RND3     = (SUM_W + 1)'(8);
  localparam logic [SUM_W:0]   RND5     = (SUM_W + 1)'(136);
  localparam logic [SUM_W:0]   DIV5     = (SUM_W + 1)'(273);
  localparam int W3 [9]  = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
  localparam int W5 [25] = '{1, 4, 7, 4, 1, 4, 16, 26, 16, 4, 7, 26, 41, 26, 7,
                             4, 16, 26, 16, 4, 1, 4, 7, 4, 1};

  logic [PW-1:0]    din [5];
  logic [PW-1:0]    tap [5][5];
  logic [COL_W-1:0] col;
  logic [1:0]       mode_r;
  logic [1:0]       mode_eff;
  logic             qualified;
  logic             q_valid, q_eol;
  logic [1:0]       q_mode;
  logic [SUM_W-1:0] sum [CHANNELS];
  logic             s_valid, s_eol;
  logic [1:0]       s_mode;
  logic [SUM_W-1:0] s_sum [CHANNELS];
  logic [SUM_W:0]   acc;
  logic [PW-1:0]    result;

  assign din[0] = px.din1;
  assign din[1] = px.din2;
  assign din[2] = px.din3;
  assign din[3] = px.din4;
  assign din[4] = px.din5;

  // The column-0 beat already runs in the newly sampled mode.
  assign mode_eff = (col == '0) ? px.mode : mode_r;

  always_comb begin
    case (mode_eff)
      2'd1:    qualified = (col >= COL_W'(2));
      2'd2:    qualified = (col >= COL_W'(4));
      default: qualified = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 5; r++)
        for (int k = 0; k < 5; k++)
          tap[r][k] <= '0;
      col     <= '0;
      mode_r  <= '0;
      q_valid <= 1'b0;
      q_eol   <= 1'b0;
      q_mode  <= '0;
    end else begin
      q_valid <= px.valid_in && qualified;
      if (px.valid_in) begin
        for (int r = 0; r < 5; r++) begin
          tap[r][0] <= din[r];
          for (int k = 1; k < 5; k++)
            tap[r][k] <= tap[r][k-1];
        end
        col    <= (col == LAST_COL) ? '0 : col + 1'b1;
        mode_r <= mode_eff;
        q_eol  <= (col == LAST_COL);
        q_mode <= mode_eff;
      end
    end
  end

  // tap[r][0] is the newest column, so the window is centred K/2 columns back.
  always_comb begin
    for (int ch = 0; ch < CHANNELS; ch++) begin
      sum[ch] = '0;
      case (q_mode)
        2'd1: begin
          for (int r = 0; r < 3; r++)
            for (int k = 0; k < 3; k++)
              sum[ch] = sum[ch] + SUM_W'(W3[r*3+k]) * SUM_W'(tap[r+1][k][ch*CH_W +: CH_W]);
        end
        2'd2: begin
          for (int r = 0; r < 5; r++)
            for (int k = 0; k < 5; k++)
              sum[ch] = sum[ch] + SUM_W'(W5[r*5+k]) * SUM_W'(tap[r][k][ch*CH_W +: CH_W]);
        end
        default: sum[ch] = SUM_W'(tap[2][0][ch*CH_W +: CH_W]);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid <= 1'b0;
      s_eol   <= 1'b0;
      s_mode  <= '0;
      for (int ch = 0; ch < CHANNELS; ch++)
        s_sum[ch] <= '0;
    end else begin
      s_valid <= q_valid;
      s_eol   <= q_valid && q_eol;
      s_mode  <= q_mode;
      for (int ch = 0; ch < CHANNELS; ch++)
        s_sum[ch] <= sum[ch];
    end
  end

  always_comb begin
    result = '0;
    acc    = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      case (s_mode)
        2'd1:    acc = ({1'b0, s_sum[ch]} + RND3) >> 4;
        2'd2:    acc = ({1'b0, s_sum[ch]} + RND5) / DIV5;
        default: acc = {1'b0, s_sum[ch]};
      endcase
      result[ch*CH_W +: CH_W] = (acc > MAX_PIX) ? MAX_PIX[CH_W-1:0] : acc[CH_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      px.dout      <= '0;
      px.valid_out <= 1'b0;
      px.eol_out   <= 1'b0;
    end else begin
      px.valid_out <= s_valid;
      px.eol_out   <= s_eol;
      if (s_valid)
        px.dout <= result;
    end
  end
endmodule

// File: tb/tb_gaussian_window_filter.sv
// tb/tb_gaussian_window_filter.sv - randomized reference-model bench for gaussian_window_filter
module tb_gaussian_window_filter;
  localparam int CH_W = 8;
  localparam int CHANNELS = 3;
  localparam int PW = 8;
  localparam int DW = CH_W * CHANNELS;

  typedef logic [DW-1:0] pix_t;
  typedef struct packed {
    logic [31:0]   cyc;
    logic [DW-1:0] d;
    logic          eol;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  gaussian_window_filter_if #(.CH_W(CH_W), .CHANNELS(CHANNELS)) bus ();

  gaussian_window_filter #(.CH_W(CH_W), .CHANNELS(CHANNELS), .PIC_WIDTH(PW)) dut (
    .clk (clk),
    .rst (rst),
    .px  (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          fails = 0;
  logic [31:0] cyc = 0;
  ev_t         exp_q[$];
  ev_t         obs_q[$];
  pix_t        line_buf [5][PW];
  int          m_col = 0;
  int          m_mode = 0;
  int          W5 [5][5] = '{'{1, 4, 7, 4, 1}, '{4, 16, 26, 16, 4}, '{7, 26, 41, 26, 7},
                             '{4, 16, 26, 16, 4}, '{1, 4, 7, 4, 1}};

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.valid_out) obs_q.push_back({cyc, bus.dout, bus.eol_out});

  // Model: keep the current line's columns and convolve around the window centre.
  task automatic send_beat(input logic [1:0] md, input pix_t d[5]);
    int k, h, cc, s, v, w, adr, adc;
    pix_t res;
    @(negedge clk);
    bus.valid_in = 1'b1;
    bus.mode = md;
    bus.din1 = d[0]; bus.din2 = d[1]; bus.din3 = d[2]; bus.din4 = d[3]; bus.din5 = d[4];
    if (m_col == 0) m_mode = int'(md);
    for (int r = 0; r < 5; r++) line_buf[r][m_col] = d[r];
    k = (m_mode == 1) ? 3 : (m_mode == 2) ? 5 : 1;
    if (m_col >= k - 1) begin
      res = '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        if (k == 1) begin
          v = int'(d[2][ch*CH_W +: CH_W]);
        end else begin
          h = (k - 1) / 2;
          cc = m_col - h;
          s = 0;
          for (int dr = -h; dr <= h; dr++)
            for (int dc = -h; dc <= h; dc++) begin
              adr = (dr < 0) ? -dr : dr;
              adc = (dc < 0) ? -dc : dc;
              w = (k == 3) ? (2 - adr) * (2 - adc) : W5[dr+2][dc+2];
              s += w * int'(line_buf[2+dr][cc+dc][ch*CH_W +: CH_W]);
            end
          v = (k == 3) ? (s + 8) / 16 : (s + 136) / 273;
        end
        if (v > 255) v = 255;
        res[ch*CH_W +: CH_W] = v[7:0];
      end
      exp_q.push_back({cyc + 32'd3, res, (m_col == PW - 1)});
    end
    m_col = (m_col + 1) % PW;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.valid_in = 1'b0;
      bus.mode = 2'($urandom);
      bus.din1 = pix_t'($urandom); bus.din2 = pix_t'($urandom); bus.din3 = pix_t'($urandom);
      bus.din4 = pix_t'($urandom); bus.din5 = pix_t'($urandom);
    end
  endtask

  task automatic rand_col(output pix_t d[5]);
    for (int r = 0; r < 5; r++) d[r] = pix_t'($urandom);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (bus.valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", bus.valid_out); end
    checks++;
    if (bus.eol_out !== 1'b0) begin fails++; $display("FAIL reset_eol got %b want 0", bus.eol_out); end
    checks++;
    if (bus.dout !== '0) begin fails++; $display("FAIL reset_dout got %h want 0", bus.dout); end
    rst = 1'b0;
    m_col = 0; m_mode = 0;
    idle(2);
  endtask

  task automatic test_flat();
    pix_t d[5];
    ev_t e, o;
    for (int r = 0; r < 5; r++) d[r] = {3{8'd100}};
    for (int c = 0; c < PW; c++) send_beat(2'd2, d);
    idle(4);
    checks++;
    if (obs_q.size() != 4) begin fails++; $display("FAIL flat_count got %0d want 4", obs_q.size()); end
    checks++;
    if (obs_q.size() > 3 && (obs_q[3].eol !== 1'b1 || obs_q[0].d !== {3{8'd100}})) begin
      fails++; $display("FAIL flat_value got d=%h eol4=%b want d=646464 eol4=1", obs_q[0].d, obs_q[3].eol);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL flat_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin fails++; $display("FAIL flat_out got cyc=%0d d=%h eol=%b want cyc=%0d d=%h eol=%b", o.cyc, o.d, o.eol, e.cyc, e.d, e.eol); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_impulse();
    pix_t d[5];
    ev_t e, o;
    int mx, want;
    for (int pass = 0; pass < 2; pass++) begin
      for (int c = 0; c < PW; c++) begin
        for (int r = 0; r < 5; r++) d[r] = '0;
        if (c == 4) d[2] = 24'h0000ff;
        send_beat((pass == 0) ? 2'd2 : 2'd1, d);
      end
      idle(4);
      want = (pass == 0) ? 38 : 64;
      mx = 0;
      foreach (obs_q[i]) if (int'(obs_q[i].d[7:0]) > mx) mx = int'(obs_q[i].d[7:0]);
      checks++;
      if (mx != want) begin fails++; $display("FAIL impulse_peak%0d got %0d want %0d", pass, mx, want); end
      checks++;
      if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL impulse_len got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
        if (o !== e) begin fails++; $display("FAIL impulse_out got cyc=%0d d=%h eol=%b want cyc=%0d d=%h eol=%b", o.cyc, o.d, o.eol, e.cyc, e.d, e.eol); end
      end
      exp_q.delete(); obs_q.delete();
    end
  endtask

  task automatic test_saturation();
    pix_t d[5];
    ev_t e, o;
    logic [1:0] md;
    logic [7:0] val;
    for (int t = 0; t < 4; t++) begin
      md = (t < 2) ? 2'd1 : 2'd2;
      val = t[0] ? 8'd1 : 8'd255;
      for (int r = 0; r < 5; r++) d[r] = {3{val}};
      for (int c = 0; c < PW; c++) send_beat(md, d);
      idle(4);
      checks++;
      if (obs_q.size() != ((md == 2'd1) ? 6 : 4)) begin fails++; $display("FAIL sat_count%0d got %0d", t, obs_q.size()); end
      foreach (obs_q[i]) begin
        checks++;
        if (obs_q[i].d !== {3{val}}) begin fails++; $display("FAIL sat_value%0d got %h want %h", t, obs_q[i].d, {3{val}}); end
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
        if (o !== e) begin fails++; $display("FAIL sat_out got cyc=%0d d=%h eol=%b want cyc=%0d d=%h eol=%b", o.cyc, o.d, o.eol, e.cyc, e.d, e.eol); end
      end
      exp_q.delete(); obs_q.delete();
    end
  endtask

  task automatic test_mode_switch();
    pix_t d[5];
    ev_t e, o;
    for (int c = 0; c < 2 * PW; c++) begin
      rand_col(d);
      send_beat((c < 3) ? 2'd2 : 2'd1, d);
    end
    idle(4);
    checks++;
    if (obs_q.size() != 10) begin fails++; $display("FAIL switch_count got %0d want 10", obs_q.size()); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL switch_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin fails++; $display("FAIL switch_out got cyc=%0d d=%h eol=%b want cyc=%0d d=%h eol=%b", o.cyc, o.d, o.eol, e.cyc, e.d, e.eol); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_gaps();
    pix_t d[5];
    ev_t e, o;
    for (int c = 0; c < 2 * PW; c++) begin
      rand_col(d);
      send_beat(2'd0, d);
      idle(1);
    end
    idle(4);
    checks++;
    if (obs_q.size() != 16) begin fails++; $display("FAIL gaps_count got %0d want 16", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin fails++; $display("FAIL gaps_out got cyc=%0d d=%h eol=%b want cyc=%0d d=%h eol=%b", o.cyc, o.d, o.eol, e.cyc, e.d, e.eol); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_midline();
    pix_t d[5];
    ev_t e, o;
    for (int c = 0; c < 6; c++) begin
      rand_col(d);
      send_beat(2'd2, d);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.valid_in = 1'b1;
    bus.din3 = pix_t'($urandom);
    @(negedge clk);
    checks++;
    if (bus.valid_out !== 1'b0 || bus.dout !== '0) begin
      fails++; $display("FAIL midrst_state got valid=%b dout=%h want valid=0 dout=0", bus.valid_out, bus.dout);
    end
    rst = 1'b0;
    bus.valid_in = 1'b0;
    exp_q.delete();
    m_col = 0; m_mode = 0;
    idle(4);
    checks++;
    if (obs_q.size() != 0) begin fails++; $display("FAIL midrst_flush got %0d outputs want 0", obs_q.size()); end
    obs_q.delete();
    for (int c = 0; c < PW; c++) begin
      rand_col(d);
      send_beat(2'd2, d);
    end
    idle(4);
    checks++;
    if (obs_q.size() != 4) begin fails++; $display("FAIL midrst_count got %0d want 4", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin fails++; $display("FAIL midrst_out got cyc=%0d d=%h eol=%b want cyc=%0d d=%h eol=%b", o.cyc, o.d, o.eol, e.cyc, e.d, e.eol); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random();
    pix_t d[5];
    ev_t e, o;
    logic [1:0] md;
    for (int ln = 0; ln < 10; ln++) begin
      md = 2'($urandom);
      for (int c = 0; c < PW; c++) begin
        if ($urandom_range(0, 3) == 0) md = 2'($urandom);
        rand_col(d);
        send_beat(md, d);
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
    end
    idle(4);
    checks++;
    if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL random_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin fails++; $display("FAIL random_out got cyc=%0d d=%h eol=%b want cyc=%0d d=%h eol=%b", o.cyc, o.d, o.eol, e.cyc, e.d, e.eol); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.mode = 2'd0;
    bus.din1 = '0; bus.din2 = '0; bus.din3 = '0; bus.din4 = '0; bus.din5 = '0;
    test_reset();
    test_flat();
    test_impulse();
    test_saturation();
    test_mode_switch();
    test_gaps();
    test_reset_midline();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule
